// File: rtl/axi_pkg.sv
// Shared AXI4-Lite widths, response codes and channel FSM state types
// used by the SRAM slave and its storage array.
package axi_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int CNT_W  = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

   // Offset compare keeps the upper bound from wrapping when base+span overflows 32 bits.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base,
                                          input logic [ADDR_W:0]   span);
      return (addr >= base) && ({1'b0, addr - base} < span);
   endfunction
endpackage

// File: rtl/axi_lite_sram_mem.sv
// Word array with one byte-strobed write port and one registered read port.
// A read and a write to the same word in one cycle return the old contents.
module axi_lite_sram_mem
   import axi_pkg::*;
#(
   parameter int  DEPTH = 1024,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [STRB_W-1:0] wr_strb,
   input  logic              rd_en,
   input  logic              rd_clr,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en)       rd_data_d = mem_q[rd_idx];
      else if (rd_clr) rd_data_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_data_q <= '0;
      else      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave SRAM with independent read/write channel FSMs and
// programmable response latency; out-of-range accesses answer DECERR.
//
// state  | meaning
// R_IDLE | arready high, waiting for an AR beat
// R_WAIT | latency down-counter running, array not yet sampled
// R_RESP | rvalid high, holding rdata/rresp until rready
// W_IDLE | collecting AW and W beats in any order
// W_WAIT | both beats held, latency down-counter running
// W_RESP | write committed, bvalid high until bready
module axi_lite_sram
   import axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          DEPTH     = 1024,
   parameter int          RD_LAT    = 2,
   parameter int          WR_LAT    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp
);
   localparam int              IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DEPTH * 4);

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   rd_state_t         rd_state_q, rd_state_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_smp_addr;
   logic              arready_q, arready_d, rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rd_ok, rd_en, rd_clr;

   assign rd_smp_addr = (rd_state_q == R_IDLE) ? araddr : rd_addr_q;
   assign rd_ok       = addr_in_range(rd_smp_addr, BASE_ADDR, SPAN);

   always_comb begin
      rd_state_d = rd_state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_addr_d  = rd_addr_q;
      rresp_d    = rresp_q;
      rd_en      = 1'b0;
      rd_clr     = 1'b0;
      case (rd_state_q)
         R_IDLE: if (arvalid && arready_q) begin
            rd_addr_d = araddr;
            if (RD_LAT == 0) rd_state_d = R_RESP;
            else begin
               rd_state_d = R_WAIT;
               rd_cnt_d   = CNT_W'(RD_LAT - 1);
            end
         end
         R_WAIT: if (rd_cnt_q == '0) rd_state_d = R_RESP;
                 else                rd_cnt_d   = rd_cnt_q - 1'b1;
         R_RESP: if (rready) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
      if (rd_state_d == R_RESP && rd_state_q != R_RESP) begin
         rd_en   = rd_ok;
         rd_clr  = !rd_ok;
         rresp_d = rd_ok ? RESP_OKAY : RESP_DECERR;
      end
      arready_d = (rd_state_d == R_IDLE);
      rvalid_d  = (rd_state_d == R_RESP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_state_q <= R_IDLE;
         rd_cnt_q   <= '0;
         rd_addr_q  <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_addr_q  <= rd_addr_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
      end
   end

   wr_state_t         wr_state_q, wr_state_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d, wr_addr_cur;
   logic [DATA_W-1:0] wdata_q, wdata_d, wr_data_cur;
   logic [STRB_W-1:0] wstrb_q, wstrb_d, wr_strb_cur;
   logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              aw_hs, w_hs, wr_ok, wr_en;

   // A beat handshaking this cycle is used directly so zero latency commits on time.
   assign aw_hs       = awvalid && awready_q;
   assign w_hs        = wvalid && wready_q;
   assign wr_addr_cur = aw_hs ? awaddr : awaddr_q;
   assign wr_data_cur = w_hs ? wdata : wdata_q;
   assign wr_strb_cur = w_hs ? wstrb : wstrb_q;
   assign wr_ok       = addr_in_range(wr_addr_cur, BASE_ADDR, SPAN);

   always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      aw_got_d   = aw_got_q;
      w_got_d    = w_got_q;
      bresp_d    = bresp_q;
      wr_en      = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               awaddr_d = awaddr;
               aw_got_d = 1'b1;
            end
            if (w_hs) begin
               wdata_d = wdata;
               wstrb_d = wstrb;
               w_got_d = 1'b1;
            end
            if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               if (WR_LAT == 0) wr_state_d = W_RESP;
               else begin
                  wr_state_d = W_WAIT;
                  wr_cnt_d   = CNT_W'(WR_LAT - 1);
               end
            end
         end
         W_WAIT: if (wr_cnt_q == '0) wr_state_d = W_RESP;
                 else                wr_cnt_d   = wr_cnt_q - 1'b1;
         W_RESP: if (bready) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
      if (wr_state_d == W_RESP && wr_state_q != W_RESP) begin
         wr_en   = wr_ok;
         bresp_d = wr_ok ? RESP_OKAY : RESP_DECERR;
      end
      awready_d = (wr_state_d == W_IDLE) && !aw_got_d;
      wready_d  = (wr_state_d == W_IDLE) && !w_got_d;
      bvalid_d  = (wr_state_d == W_RESP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_state_q <= W_IDLE;
         wr_cnt_q   <= '0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         aw_got_q   <= 1'b0;
         w_got_q    <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_cnt_q   <= wr_cnt_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         aw_got_q   <= aw_got_d;
         w_got_q    <= w_got_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
      end
   end

   axi_lite_sram_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_idx  (word_idx(wr_addr_cur)),
      .wr_data (wr_data_cur),
      .wr_strb (wr_strb_cur),
      .rd_en   (rd_en),
      .rd_clr  (rd_clr),
      .rd_idx  (word_idx(rd_smp_addr)),
      .rd_data (rdata)
   );

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_sram.sv
// Bench for axi_lite_sram: directed vector table, corner sequences and a
// randomized phase against a word-array reference model.
module tb_axi_lite_sram;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          EXP_LAT = 3;

   logic        clk = 1'b0, rst = 1'b0;
   logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
   logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
   logic [3:0]  wstrb = 0;
   logic [1:0]  bresp, rresp;
   logic        arvalid = 0, arready, rvalid, rready = 0;

   int n_chk = 0, n_fail = 0;
   logic [31:0] mdl [int];

   always #5 clk = ~clk;

   axi_lite_sram dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'd4096);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] cur;
      if (!in_rng(a)) return;
      cur = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
      mdl[widx(a)] = cur;
   endtask

   function automatic logic [31:0] mdl_rdata(input logic [31:0] a);
      return in_rng(a) ? mdl[widx(a)] : 32'h0;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] a);
      return in_rng(a) ? 2'b00 : 2'b11;
   endfunction

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_at, input int w_at, input bit b_hold, input bit abort,
                            input logic [1:0] exp_b);
      bit aw_p = 1, w_p = 1, aw_hs, w_hs;
      int n = 0, lat;
      bready = b_hold;
      while ((aw_p || w_p) && n < 40) begin
         if (aw_p && n >= aw_at) begin awvalid = 1; awaddr = a; end
         if (w_p && n >= w_at) begin wvalid = 1; wdata = d; wstrb = s; end
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick(); n++;
         if (aw_hs) begin aw_p = 0; awvalid = 0; end
         if (w_hs)  begin w_p = 0;  wvalid = 0;  end
         if (w_at < aw_at && !w_p && aw_p) begin
            chk("wready_after_w", wready, 0);
            chk("awready_waiting", awready, 1);
         end
      end
      chk("wr_hs_timeout", aw_p || w_p, 0);
      if (abort) return;
      lat = 1;
      while (!bvalid && lat < 40) begin tick(); lat++; end
      chk("b_timeout", bvalid, 1);
      chk("wr_latency", lat, EXP_LAT);
      chk("bresp", bresp, exp_b);
      bready = 1;
      tick();
      bready = 0;
      chk("bvalid_clear", bvalid, 0);
      chk("aw_w_ready_back", {awready, wready}, 2'b11);
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input int hold, output logic [31:0] got);
      int n = 0, lat;
      arvalid = 1; araddr = a;
      while (!arready && n < 40) begin tick(); n++; end
      chk("ar_timeout", arready, 1);
      tick();
      arvalid = 0;
      lat = 1;
      while (!rvalid && lat < 40) begin
         chk("arready_busy", arready, 0);
         tick(); lat++;
      end
      chk("r_timeout", rvalid, 1);
      chk("rd_latency", lat, EXP_LAT);
      chk("rdata", rdata, exp_d);
      chk("rresp", rresp, exp_r);
      got = rdata;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("r_hold_valid", rvalid, 1);
         chk("r_hold_data", rdata, exp_d);
         chk("r_hold_resp", rresp, exp_r);
         chk("r_hold_arready", arready, 0);
      end
      rready = 1;
      tick();
      rready = 0;
      chk("rvalid_clear", rvalid, 0);
      chk("arready_back", arready, 1);
   endtask

   typedef struct {
      bit          pre;
      logic [31:0] waddr, wdata;
      logic [3:0]  wstrb;
      logic [1:0]  bresp;
      logic [31:0] raddr, rdata;
      logic [1:0]  rresp;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [31:0] got, a, d, dsum, msum;
      logic [3:0]  s;

      vecs[0] = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00};
      vecs[1] = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'h5, 2'b00, 32'h8000_0020, 32'hFF22_FF44, 2'b00};
      vecs[2] = '{1'b1, 32'h8000_0024, 32'h0000_0000, 4'h0, 2'b00, 32'h8000_0024, 32'hFFFF_FFFF, 2'b00};
      vecs[3] = '{1'b1, 32'h8000_0FFC, 32'hA5A5_0000, 4'hC, 2'b00, 32'h8000_0FFE, 32'hA5A5_FFFF, 2'b00};
      vecs[4] = '{1'b0, 32'h8000_1000, 32'h1234_5678, 4'hF, 2'b11, 32'h8000_1000, 32'h0000_0000, 2'b11};
      vecs[5] = '{1'b0, 32'h7FFF_FFFC, 32'hCAFE_F00D, 4'hF, 2'b11, 32'h7FFF_FFFC, 32'h0000_0000, 2'b11};
      vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_00AB, 4'h1, 2'b00, 32'h8000_0003, 32'hFFFF_FFAB, 2'b00};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctl_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
      chk("reset_rdata", rdata, 0);
      rst = 1;
      chk("arready_at_release", arready, 0);
      tick();
      chk("readies_after_release", {arready, awready, wready}, 3'b111);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].pre) begin
            axi_write(vecs[i].waddr, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 2'b00);
            mdl_write(vecs[i].waddr, 32'hFFFF_FFFF, 4'hF);
         end
         axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, 0, 0, 0, 0, vecs[i].bresp);
         mdl_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
         axi_read(vecs[i].raddr, vecs[i].rdata, vecs[i].rresp, 0, got);
      end

      axi_write(32'h8000_0040, 32'h0F1E_2D3C, 4'hF, 3, 0, 1, 0, 2'b00);
      mdl_write(32'h8000_0040, 32'h0F1E_2D3C, 4'hF);
      axi_read(32'h8000_0040, 32'h0F1E_2D3C, 2'b00, 0, got);

      axi_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 5, got);

      axi_write(32'h8000_0080, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 2'b00);
      mdl_write(32'h8000_0080, 32'h1234_5678, 4'hF);
      axi_write(32'h8000_0080, 32'h5555_5555, 4'hF, 0, 0, 0, 1, 2'b00);
      rst = 0;
      #1;
      chk("midreset_ctl_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
      chk("midreset_rdata", rdata, 0);
      tick();
      chk("midreset_ctl_outputs_2", {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
      rst = 1;
      chk("arready_at_rerelease", arready, 0);
      tick();
      chk("readies_after_rerelease", {arready, awready, wready}, 3'b111);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_stray_bvalid", bvalid, 0);
      end
      axi_read(32'h8000_0080, 32'h1234_5678, 2'b00, 0, got);

      for (int i = 0; i < 32; i++) begin
         d = $urandom;
         axi_write(BASE + 32'(4 * i), d, 4'hF, 0, 0, 0, 0, 2'b00);
         mdl_write(BASE + 32'(4 * i), d, 4'hF);
      end
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 1) ? 32'h8000_1000 + 32'($urandom_range(0, 4095))
                                            : 32'h7FFF_F000 + 32'($urandom_range(0, 4095));
         else
            a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, exp_resp(a));
            mdl_write(a, d, s);
         end else begin
            axi_read(a, mdl_rdata(a), exp_resp(a), $urandom_range(0, 2), got);
         end
      end

      dsum = 0;
      msum = 0;
      foreach (mdl[k]) begin
         axi_read(BASE + 32'(4 * k), mdl[k], 2'b00, 0, got);
         dsum = dsum + got;
         msum = msum + mdl[k];
      end
      chk("array_checksum", dsum, msum);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
